// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h1000_0010;
    localparam int unsigned IRQ_MAX_SRC    = 16;

endpackage : irq_pkg

// File: rtl/irq_prio_enc.sv
// Wrapping priority encoder: first set bit of pend at or above start, wrapping past N_SRC-1 to 0.
module irq_prio_enc #(
    parameter  int unsigned N_SRC = 16,
    localparam int unsigned IW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] pend,
    input  logic [IW-1:0]    start,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(N_SRC)) begin
                pos = pos - (IW+1)'(N_SRC);
            end
            if (pend[pos[IW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/irq_arbiter.sv
// Multi-source interrupt arbiter: picks one masked request, hands it to the core, acks on return.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC       = IRQ_MAX_SRC,
    parameter logic [31:0] CAUSE_BASE  = IRQ_CAUSE_BASE,
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             irq_taken_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] irq_ack_o,
    output logic             busy_o
);

    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_t        state;
    logic [N_SRC-1:0]  pend;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     start;
    logic [IW-1:0]     win_idx;
    logic              win_valid;

    // Only enabled requests take part in arbitration.
    assign pend  = irq_src_i & irq_mask_i;

    // Fixed priority always searches from index 0.
    assign start = ROUND_ROBIN ? rr_ptr : '0;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .pend  (pend),
        .start (start),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Arbitration FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            rr_ptr      <= '0;
            irq_req_o   <= 1'b0;
            irq_cause_o <= CAUSE_BASE;
            irq_ack_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            irq_ack_o <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        idx         <= win_idx;
                        irq_cause_o <= CAUSE_BASE + 32'(win_idx);
                        irq_req_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // Acceptance by the core beats a same-cycle withdrawal.
                    if (irq_taken_i) begin
                        irq_req_o <= 1'b0;
                        state     <= SVC;
                    end else if (!pend[idx]) begin
                        irq_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                SVC: begin
                    if (irq_ret_i) begin
                        irq_ack_o <= N_SRC'(1) << idx;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (ROUND_ROBIN) begin
                        rr_ptr <= (idx == IW'(N_SRC - 1)) ? '0 : idx + IW'(1);
                    end
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    irq_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : irq_arbiter
